md_unit: RTL

- Iterative multiply/divide unit with architectural HI/LO registers, living in the EX stage.
- Receives forwarded rs/rt operands and a decoded op from the EX datapath.
- HI/LO values feed the EX result mux for mfhi/mflo, and from there the EX→MEM pipeline register.
- Emits a stall request to the ID/EX hazard logic while a long-latency operation is in flight.

---
 rtl/md_unit_if.sv | 24 ++
 rtl/md_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/md_unit_if.sv
// EX-stage handshake between the datapath and the multiply/divide unit.
// The datapath drives through master; md_unit connects through slave.
interface md_unit_if;
    logic        op_valid_i;
    logic [2:0]  md_op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic        id_is_md_i;
    logic        start_o;
    logic        busy_o;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output op_valid_i, md_op_i, rs_i, rt_i, id_is_md_i,
        input  start_o, busy_o, stall_o, hi_o, lo_o
    );

    modport slave (
        input  op_valid_i, md_op_i, rs_i, rt_i, id_is_md_i,
        output start_o, busy_o, stall_o, hi_o, lo_o
    );
endinterface

// File: rtl/md_unit.sv
// Iterative-latency multiply/divide unit holding the architectural HI/LO pair.
// The result is computed at issue and committed after MULT_CYCLES/DIV_CYCLES busy cycles.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      reset,
    md_unit_if.slave md
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [31:0]      hi_q, hi_n;
    logic [31:0]      lo_q, lo_n;
    logic [31:0]      pend_hi_q, pend_hi_n;
    logic [31:0]      pend_lo_q, pend_lo_n;
    logic             pend_wr_q, pend_wr_n;

    md_op_t      op;
    logic        busy;
    logic        start;
    logic        is_mult;
    logic        signed_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] div_by;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_zero;

    assign op      = md_op_t'(md.md_op_i);
    assign busy    = (state_q == ST_BUSY);
    assign is_mult = (op == OP_MULT) || (op == OP_MULTU);
    assign start   = md.op_valid_i && !busy &&
                     ((op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU));

    // Signed divide works on magnitudes; the 0x80000000 / -1 case falls out as 0x80000000 r 0.
    always_comb begin
        prod_s     = $signed({{32{md.rs_i[31]}}, md.rs_i}) * $signed({{32{md.rt_i[31]}}, md.rt_i});
        prod_u     = {32'd0, md.rs_i} * {32'd0, md.rt_i};
        signed_div = (op == OP_DIV);
        rs_mag     = (signed_div && md.rs_i[31]) ? (~md.rs_i + 32'd1) : md.rs_i;
        rt_mag     = (signed_div && md.rt_i[31]) ? (~md.rt_i + 32'd1) : md.rt_i;
        div_zero   = (md.rt_i == '0);
        div_by     = div_zero ? 32'd1 : rt_mag;
        quo_mag    = rs_mag / div_by;
        rem_mag    = rs_mag % div_by;
        quo        = (signed_div && (md.rs_i[31] ^ md.rt_i[31])) ? (~quo_mag + 32'd1) : quo_mag;
        rem        = (signed_div && md.rs_i[31]) ? (~rem_mag + 32'd1) : rem_mag;
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        hi_n      = hi_q;
        lo_n      = lo_q;
        pend_hi_n = pend_hi_q;
        pend_lo_n = pend_lo_q;
        pend_wr_n = pend_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_BUSY;
                    if (is_mult) begin
                        cnt_n     = CNT_W'(MULT_CYCLES);
                        pend_wr_n = 1'b1;
                        {pend_hi_n, pend_lo_n} = (op == OP_MULT) ? prod_s : prod_u;
                    end else begin
                        cnt_n     = CNT_W'(DIV_CYCLES);
                        pend_wr_n = !div_zero;
                        pend_hi_n = rem;
                        pend_lo_n = quo;
                    end
                end else if (md.op_valid_i && (op == OP_MTHI)) begin
                    hi_n = md.rs_i;
                end else if (md.op_valid_i && (op == OP_MTLO)) begin
                    lo_n = md.rs_i;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_n   = ST_IDLE;
                    cnt_n     = '0;
                    pend_wr_n = 1'b0;
                    if (pend_wr_q) begin
                        hi_n = pend_hi_q;
                        lo_n = pend_lo_q;
                    end
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            hi_q      <= hi_n;
            lo_q      <= lo_n;
            pend_hi_q <= pend_hi_n;
            pend_lo_q <= pend_lo_n;
            pend_wr_q <= pend_wr_n;
        end
    end

    assign md.start_o = start;
    assign md.busy_o  = busy;
    assign md.stall_o = md.id_is_md_i && (start || busy);
    assign md.hi_o    = hi_q;
    assign md.lo_o    = lo_q;
endmodule
